// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receive front end.
// Oversamples the asynchronous line at 16x baud using a clock-enable tick.
// Each bit is decided by a 3-sample majority vote at sample indices 7, 8 and 9.
// Each recovered byte is presented with a one-cycle data_valid strobe.
// A bad stop bit produces a one-cycle frame_error strobe instead.
module uart_rx_sampler #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error
);

    localparam int SAMPLE_CLK_RATIO = CLK_FREQ / BAUD_RATE / 16;
    localparam int CNT_W = (SAMPLE_CLK_RATIO > 1) ? $clog2(SAMPLE_CLK_RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CLK_RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Majority of three samples; tolerates a single corrupted sample.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             s7_q, s7_d;
    logic             s8_q, s8_d;
    logic             sync_q, sync_d;
    logic             din_s_q, din_s_d;
    logic             din_d_q, din_d_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_error_q, frame_error_d;

    logic             tick_s;
    logic             start_edge_s;
    logic             maj_s;

    // Decode tick, start edge and current bit vote from registered state.
    always_comb begin
        tick_s       = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
        start_edge_s = din_d_q & ~din_s_q;
        maj_s        = maj3(s7_q, s8_q, din_s_q);
    end

    // Next-state logic: synchronizer, tick/sample counters, frame FSM, outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        s7_d          = s7_q;
        s8_d          = s8_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        // Two-flop synchronizer followed by one cycle of edge history.
        sync_d  = din;
        din_s_d = sync_q;
        din_d_d = din_s_q;

        // Tick counter is parked at zero while idle so sample phase follows the start edge.
        if (state_q == ST_IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Sample index advances once per tick and wraps 15 -> 0 at end of bit.
        if (tick_s) begin
            idx_d = idx_q + 4'd1;
        end else begin
            idx_d = idx_q;
        end

        // Capture the first two votes of the bit; the third is taken live at index 9.
        if (tick_s && (idx_q == 4'd7)) begin
            s7_d = din_s_q;
        end else if (tick_s && (idx_q == 4'd8)) begin
            s8_d = din_s_q;
        end else begin
            s7_d = s7_q;
            s8_d = s8_q;
        end

        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                if (start_edge_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (idx_q == 4'd9) && maj_s) begin
                    // Start bit did not hold low through mid-bit: treat as a glitch.
                    state_d = ST_IDLE;
                end else if (tick_s && (idx_q == 4'd15)) begin
                    state_d  = ST_DATA;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (idx_q == 4'd9)) begin
                    // Line is LSB first, so shift in from the MSB side.
                    shift_d = {maj_s, shift_q[7:1]};
                end else if (tick_s && (idx_q == 4'd15)) begin
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick_s && (idx_q == 4'd9)) begin
                    state_d = ST_IDLE;
                    if (maj_s) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset assumes an idle (high) line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            idx_q         <= 4'd0;
            bitcnt_q      <= 3'd0;
            shift_q       <= 8'h00;
            s7_q          <= 1'b1;
            s8_q          <= 1'b1;
            sync_q        <= 1'b1;
            din_s_q       <= 1'b1;
            din_d_q       <= 1'b1;
            data_q        <= 8'h00;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            s7_q          <= s7_d;
            s8_q          <= s8_d;
            sync_q        <= sync_d;
            din_s_q       <= din_s_d;
            din_d_q       <= din_d_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler.
// The baud rate is scaled so that one bit is 128 clk (8 clk per sample tick).
// A serial line driver queues the expected event for each frame.
// A monitor consumes those events on every strobe.
module tb_uart_rx_sampler;

    localparam int BIT = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;

    int total = 0;
    int bad   = 0;

    // Expected events: {is_frame_error, byte}
    logic [8:0] exp_q[$];
    logic [8:0] ev;
    logic [7:0] model_last = 8'h00;

    uart_rx_sampler #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (781_250)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .data        (data),
        .data_valid  (data_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (data_valid || frame_error) begin
            chk("strobe_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
            chk("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                chk("strobe_kind", {31'd0, frame_error}, {31'd0, ev[8]});
                if (ev[8]) begin
                    chk("err_data_hold", {24'd0, data}, {24'd0, model_last});
                end else begin
                    chk("rx_data", {24'd0, data}, {24'd0, ev[7:0]});
                    model_last = ev[7:0];
                end
            end
        end
    end

    // Drive one 8N1 frame at the given bit period, then an optional idle gap.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop,
                              input int gap, input bit expect_it);
        if (expect_it) exp_q.push_back({~stop, b});
        din = 1'b0;
        repeat (per) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (per) @(posedge clk);
        end
        din = stop;
        repeat (per) @(posedge clk);
        if (gap > 0) begin
            din = 1'b1;
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic idle_and_drain(input string tag, input int n);
        din = 1'b1;
        repeat (n) @(posedge clk);
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        int         rper;
        logic       rstop;
        int         rgap;

        rst = 1'b1;
        din = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        model_last = 8'h00;
        idle_and_drain("idle_after_reset", 50);

        // Single nominal frame
        send_frame(8'h55, BIT, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("frame_55", 10);

        // Back-to-back frames with no idle gap
        send_frame(8'hA3, BIT, 1'b1, 0, 1'b1);
        send_frame(8'h0F, BIT, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("back_to_back", 10);

        // Short low glitch on an idle line must be rejected
        din = 1'b0;
        repeat (24) @(posedge clk);
        idle_and_drain("glitch", 4 * BIT);
        send_frame(8'h3C, BIT, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("after_glitch", 10);

        // Good frame followed by a frame with a bad stop bit, line then held low
        send_frame(8'h11, BIT, 1'b1, BIT, 1'b1);
        send_frame(8'hC5, BIT, 1'b0, 0, 1'b1);
        din = 1'b0;
        repeat (4 * BIT) @(posedge clk);
        chk("break_no_frames", exp_q.size(), 32'd0);
        idle_and_drain("break_release", 2 * BIT);
        chk("data_after_break", {24'd0, data}, 32'h11);

        // Reset during data bit 4 of a 0xFF frame
        fork
            send_frame(8'hFF, BIT, 1'b1, 2 * BIT, 1'b0);
            begin
                repeat (5 * BIT + BIT / 2) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                chk("midreset_data", {24'd0, data}, 32'd0);
                chk("midreset_valid", {31'd0, data_valid}, 32'd0);
                chk("midreset_ferr", {31'd0, frame_error}, 32'd0);
                model_last = 8'h00;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle_and_drain("aborted_frame", 10);
        chk("data_after_abort", {24'd0, data}, 32'd0);
        send_frame(8'h81, BIT, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("after_abort", 10);

        // Baud tolerance at -3% and +3%
        send_frame(8'h96, 124, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("baud_minus3", 10);
        send_frame(8'h96, 132, 1'b1, 2 * BIT, 1'b1);
        idle_and_drain("baud_plus3", 10);

        // Randomized frames: random byte, period, stop bit and gap
        for (int k = 0; k < 10; k++) begin
            rb    = 8'($urandom);
            rper  = $urandom_range(125, 131);
            rstop = ($urandom_range(0, 3) != 0);
            rgap  = rstop ? $urandom_range(0, 40) : $urandom_range(8, 40);
            send_frame(rb, rper, rstop, rgap, 1'b1);
        end
        idle_and_drain("random_frames", 2 * BIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- UART receive front end for the serial transceiver datapath, in the 100 MHz `clk` domain.
- Consumes the raw asynchronous serial line `din` and oversamples it at 16x the baud rate, using an internal clock-enable tick rather than a divided clock.
- Recovers 8N1 frames and presents each byte with a one-cycle valid strobe to the downstream transceiver/transmit logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in baud.
- SAMPLE_CLK_RATIO (localparam), CLK_FREQ / BAUD_RATE / 16 (651 at defaults), clk cycles per sample tick. One bit time = 16 * 651 = 10416 clk.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw serial line; idle high; not synchronous to clk.
- data  output  8  last correctly received byte, LSB received first.
- data_valid  output  1  one-cycle pulse; `data` updated in the same cycle.
- frame_error  output  1  one-cycle pulse on bad stop bit.

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: `data` = 8'h00, `data_valid` = 0, `frame_error` = 0, state IDLE, tick counter 0, sample index 0.
  - Both synchronizer flops and the edge-history flop reset to 1, so an idle line is assumed.
- Synchronizer: 2-flop chain on `din` gives `din_s`. `din_d` is `din_s` delayed one cycle.
- Start edge: `din_d` = 1 and `din_s` = 0. A line that is already low out of reset or after a break cannot start a frame until it returns high.
- Tick generator:
  - Counter runs 0..SAMPLE_CLK_RATIO-1 only while not IDLE.
  - `tick` is asserted for one cycle when the count is SAMPLE_CLK_RATIO-1; the counter then wraps to 0.
  - The counter is forced to 0 in IDLE, so sample phase is aligned to the detected start edge.
- Sample index: 4 bits, 0..15, increments on each tick and wraps 15->0 (wrap = end of bit).
- Majority vote: `din_s` is captured at ticks with sample index 7, 8 and 9. The bit value is the majority of the 3 captures.
- States:
  - IDLE: on start edge -> START, with tick counter = 0 and sample index = 0.
  - START: at the tick with index 9, evaluate the majority.
    - Majority 1 (glitch): -> IDLE with no output.
    - Majority 0: stay in START until the tick with index 15, then -> DATA with bit count = 0.
  - DATA: at the tick with index 9, shift the majority into the shift register from the MSB side (LSB first on the line).
    - At the tick with index 15: if bit count = 7 -> STOP, else increment bit count.
  - STOP: at the tick with index 9, evaluate the majority, then -> IDLE. Exit at mid-stop is what allows back-to-back frames.
    - Majority 1: register `data` <= shift register and pulse `data_valid` in the next clk cycle.
    - Majority 0: pulse `frame_error` in the next clk cycle; `data` is unchanged.
- Latency: `data_valid`/`frame_error` rise 1 clk after the stop-bit index-9 tick. Nominally about 9.6 bit times plus 3 clk (synchronizer and edge detect) after the start falling edge at the pin.
- Pulse rules:
  - `data_valid` and `frame_error` are never high together.
  - Each is high exactly 1 clk per frame.
- Tolerance: accepts an incoming baud rate within ±3% of nominal.
- Reset mid-frame: aborts immediately to IDLE. No pulse is produced and `data` returns to 0.
- A start edge during STOP is not looked for, because STOP exits to IDLE first.

Test Plan:
- Reset, idle line high, drive frame 0x55 at 10416 clk/bit -> exactly one `data_valid` pulse, `data` = 0x55, `frame_error` stays 0.
- Back-to-back frames 0xA3 then 0x0F, with the stop bit of the first at its full 10416 clk and no idle gap -> two `data_valid` pulses, `data` = 0xA3 then 0x0F.
- Low glitch of 1953 clk (3 sample periods) on an idle line -> no `data_valid`, no `frame_error`; FSM back in IDLE; a subsequent 0x3C frame is received correctly.
- Frame 0xC5 following a good 0x11, with the stop bit driven 0 -> one `frame_error` pulse; `data` stays 0x11.
  - Line held low afterwards produces no further frames until it returns high.
- Assert `rst` during data bit 4 of a 0xFF frame -> outputs 0 immediately, no pulse.
  - After release the remainder of the aborted frame produces no byte and no `frame_error`; the next full frame 0x81 is received correctly.
- Frames 0x96 sent at bit periods of 10104 and 10728 clk (−3% / +3%) -> `data` = 0x96 with `data_valid` in both cases.
